// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: pipeline MEM stage (port 0)
// versus loader/debug (port 1), round-robin with a capped locked burst for port 1.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_stall,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic          p1_lock,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_pos,
  output logic [DW-1:0] mem_data,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_out,
  output logic [1:0]    arb_state
);

  // state | meaning
  // IDLE  | no grant last cycle
  // G0    | port 0 granted last cycle
  // G1    | port 1 granted last cycle, unlocked
  // LOCK  | port 1 granted last cycle inside a locked burst
  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2, LOCK = 2'd3} state_t;

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  state_t        state, state_nxt;
  logic [CW-1:0] burst_cnt, burst_nxt;
  logic          gnt0, gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = IDLE;
    burst_nxt = '0;
    if (!rst) begin
      if (p0_req && p1_req) begin
        case (state)
          G0:      gnt1 = 1'b1;
          LOCK:    if (p1_lock && burst_cnt < MAX_CNT) gnt1 = 1'b1;
                   else gnt0 = 1'b1;
          default: gnt0 = 1'b1;
        endcase
      end else begin
        gnt0 = p0_req;
        gnt1 = p1_req;
      end
    end
    if (gnt1 && p1_lock) begin
      state_nxt = LOCK;
      // Uncontended bursts run on past the cap, so hold the count at the cap.
      if (state == LOCK) burst_nxt = (burst_cnt == MAX_CNT) ? burst_cnt : burst_cnt + 1'b1;
      else               burst_nxt = CW'(1);
    end else if (gnt1) begin
      state_nxt = G1;
    end else if (gnt0) begin
      state_nxt = G0;
    end
  end

  always_comb begin
    mem_pos  = '0;
    mem_data = '0;
    mem_wr   = 1'b0;
    p0_rdata = '0;
    p1_rdata = '0;
    if (gnt0) begin
      mem_pos  = p0_addr;
      mem_data = p0_wdata;
      mem_wr   = p0_we;
      p0_rdata = mem_out;
    end else if (gnt1) begin
      mem_pos  = p1_addr;
      mem_data = p1_wdata;
      mem_wr   = p1_we;
      p1_rdata = mem_out;
    end
  end

  assign p0_ack    = gnt0;
  assign p1_ack    = gnt1;
  assign p0_stall  = p0_req & ~gnt0 & ~rst;
  assign arb_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory;
// inputs change at negedge, outputs are checked 1 ns later.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_ack, p0_stall;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_lock, p1_ack;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [31:0] mem_pos, mem_data, mem_out;
  logic        mem_wr;
  logic [1:0]  arb_state;

  logic [31:0] mem [0:1023];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign mem_out = mem[mem_pos[11:2]];
  always @(posedge clk) if (mem_wr) mem[mem_pos[11:2]] <= mem_data;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_stall(p0_stall),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_pos(mem_pos), .mem_data(mem_data), .mem_wr(mem_wr), .mem_out(mem_out),
    .arb_state(arb_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic lock);
    p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd; p1_lock = lock;
  endtask

  // Advance to the next negedge; caller drives, waits #1, then checks.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    cyc(); drive0(0, 0, 0, 0); drive1(0, 0, 0, 0, 0); #1;
  endtask

  logic [10:0] lock_pat;

  initial begin
    rst = 1'b1;
    drive0(1, 1, 32'h10, 32'h5555_5555);
    drive1(1, 1, 32'h14, 32'h6666_6666, 1);
    // 1: reset, then write/read-back
    cyc(); #1;
    check("rst_p0_ack", p0_ack, 0);
    check("rst_p1_ack", p1_ack, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_stall", p0_stall, 0);
    cyc(); #1;
    check("rst_state", arb_state, 0);
    cyc(); rst = 1'b0;
    drive0(1, 1, 32'h10, 32'hDEAD_BEEF); drive1(0, 0, 0, 0, 0); #1;
    check("t1_w_ack", p0_ack, 1);
    check("t1_w_wr", mem_wr, 1);
    check("t1_w_pos", mem_pos, 32'h10);
    check("t1_w_data", mem_data, 32'hDEAD_BEEF);
    cyc(); drive0(1, 0, 32'h10, 0); #1;
    check("t1_state_g0", arb_state, 1);
    check("t1_r_ack", p0_ack, 1);
    check("t1_r_wr", mem_wr, 0);
    check("t1_r_data", p0_rdata, 32'hDEAD_BEEF);
    check("t1_p1_rdata0", p1_rdata, 0);
    idle_cycle();
    check("idle_wr", mem_wr, 0);
    check("idle_pos", mem_pos, 0);

    // 2: round-robin reads, both ports always requesting
    for (int i = 0; i < 4; i++) begin
      cyc(); drive0(1, 0, 32'h10, 0); drive1(1, 0, 32'h10, 0, 0); #1;
      check($sformatf("t2_p0_ack%0d", i), p0_ack, (i % 2 == 0));
      check($sformatf("t2_p1_ack%0d", i), p1_ack, (i % 2 == 1));
      check($sformatf("t2_stall%0d", i), p0_stall, (i % 2 == 1));
    end
    check("t2_p1_rdata", p1_rdata, 32'hDEAD_BEEF);
    idle_cycle();
    cyc(); drive0(0, 0, 0, 0); #1;
    check("t2_back_idle", arb_state, 0);

    // 3: locked contention, cap of 4 port-1 beats between port-0 grants
    lock_pat = 11'b01111011110;  // bit i = expected p1 ack in cycle i
    for (int i = 0; i < 11; i++) begin
      cyc(); drive0(1, 0, 32'h10, 0); drive1(1, 0, 32'h10, 0, 1); #1;
      check($sformatf("t3_p1_ack%0d", i), p1_ack, lock_pat[i]);
      check($sformatf("t3_p0_ack%0d", i), p0_ack, !lock_pat[i]);
    end
    idle_cycle();

    // 4: uncontended locked burst of 6, then port 0 wins the next tie
    for (int i = 0; i < 6; i++) begin
      cyc(); drive0(0, 0, 0, 0); drive1(1, 0, 32'h10, 0, 1); #1;
      check($sformatf("t4_p1_ack%0d", i), p1_ack, 1);
    end
    check("t4_state_lock", arb_state, 3);
    cyc(); drive0(1, 0, 32'h10, 0); #1;
    check("t4_p0_wins", p0_ack, 1);
    check("t4_p1_waits", p1_ack, 0);
    idle_cycle();

    // 5: same-address write tie from IDLE
    cyc(); drive0(1, 1, 32'h20, 32'h1111); drive1(1, 1, 32'h20, 32'h2222, 0); #1;
    check("t5_p0_first", p0_ack, 1);
    check("t5_data0", mem_data, 32'h1111);
    cyc(); drive0(0, 0, 0, 0); #1;
    check("t5_p1_second", p1_ack, 1);
    check("t5_data1", mem_data, 32'h2222);
    cyc(); drive0(1, 0, 32'h20, 0); drive1(0, 0, 0, 0, 0); #1;
    check("t5_final", p0_rdata, 32'h2222);
    idle_cycle();

    // 6: reset in the middle of a locked burst
    cyc(); drive1(1, 1, 32'h30, 32'h3333, 1); #1;
    cyc(); #1;
    check("t6_in_lock", arb_state, 3);
    cyc(); rst = 1'b1; drive0(1, 0, 32'h10, 0); #1;
    check("t6_rst_p0_ack", p0_ack, 0);
    check("t6_rst_p1_ack", p1_ack, 0);
    check("t6_rst_wr", mem_wr, 0);
    cyc(); rst = 1'b0; #1;
    check("t6_state_idle", arb_state, 0);
    check("t6_tie_p0", p0_ack, 1);
    check("t6_tie_p1", p1_ack, 0);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
